// File: rtl/fetch_stage_pkg.sv
// Shared instruction-type codes, RV32 opcode constants and fetch FSM states.
package fetch_stage_pkg;

  typedef enum logic [2:0] {
    R_TYPE       = 3'd0,
    I_TYPE       = 3'd1,
    S_TYPE       = 3'd2,
    SB_TYPE      = 3'd3,
    U_TYPE       = 3'd4,
    UJ_TYPE      = 3'd5,
    INVALID_TYPE = 3'd7
  } inst_type_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_FLUSH = 1'b1
  } fetch_state_e;

  function automatic inst_type_e classify_opcode(input logic [6:0] opcode);
    case (opcode)
      OP_R:                                return R_TYPE;
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: return I_TYPE;
      OP_STORE:                            return S_TYPE;
      OP_BRANCH:                           return SB_TYPE;
      OP_LUI, OP_AUIPC:                    return U_TYPE;
      OP_JAL:                              return UJ_TYPE;
      default:                             return INVALID_TYPE;
    endcase
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO with occupancy count and a synchronous flush; DEPTH must be a power of two.
module fetch_queue #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_push_data,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output logic [WIDTH-1:0]           o_head,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push_en;
  logic             w_pop_en;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_pop_en  = i_pop && !o_empty;
  assign w_push_en = i_push && (!o_full || w_pop_en);

  // NOTE: storage has no reset; validity is carried entirely by the count and pointers.
  always_ff @(posedge clk) begin
    if (w_push_en && !i_flush) r_mem[r_wr_ptr] <= i_push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_en) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop_en)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push_en) - CNT_W'(w_pop_en);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Credit-based instruction fetch: issues in-order memory requests, classifies responses and
// buffers them for decode; redirects flush the buffer and drain in-flight responses.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int                    INSTRUCTION_LENGTH = 32,
  parameter int                    TYPE_WIDTH         = 3,
  parameter int                    ADDR_WIDTH         = 64,
  parameter int                    QUEUE_DEPTH        = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC           = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  output logic                          mem_req_valid,
  input  logic                          mem_req_ready,
  output logic [ADDR_WIDTH-1:0]         mem_req_addr,
  input  logic                          mem_resp_valid,
  input  logic [INSTRUCTION_LENGTH-1:0] mem_resp_data,
  input  logic                          redirect_valid,
  input  logic [ADDR_WIDTH-1:0]         redirect_pc,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [INSTRUCTION_LENGTH-1:0] out_instruction,
  output logic [TYPE_WIDTH-1:0]         out_instruction_type,
  output logic [ADDR_WIDTH-1:0]         out_pc
);

  localparam int CNT_W   = $clog2(QUEUE_DEPTH) + 1;
  localparam int ENTRY_W = INSTRUCTION_LENGTH + TYPE_WIDTH + ADDR_WIDTH;

  fetch_state_e          r_state;
  logic [ADDR_WIDTH-1:0] r_pc;

  logic [CNT_W-1:0]      w_occupancy;
  logic [CNT_W-1:0]      w_outstanding;
  logic [CNT_W:0]        w_in_use;
  logic [CNT_W-1:0]      w_outstanding_next;
  logic                  w_req_accept;
  logic                  w_addr_pop;
  logic                  w_addr_full;
  logic                  w_addr_empty;
  logic [ADDR_WIDTH-1:0] w_resp_addr;
  logic                  w_resp_push;
  logic                  w_q_full;
  logic                  w_q_empty;
  logic [ENTRY_W-1:0]    w_q_head;
  logic [ENTRY_W-1:0]    w_q_entry;
  inst_type_e            w_type;

  // Credits cover both buffered and in-flight instructions so a response always finds room.
  assign w_in_use      = {1'b0, w_occupancy} + {1'b0, w_outstanding};
  assign mem_req_valid = !reset && (r_state == ST_FETCH) && !w_addr_full
                         && (w_in_use < (CNT_W + 1)'(QUEUE_DEPTH));
  assign mem_req_addr  = r_pc;

  assign w_req_accept       = mem_req_valid && mem_req_ready && !redirect_valid;
  assign w_addr_pop         = mem_resp_valid && !w_addr_empty;
  assign w_outstanding_next = w_outstanding + CNT_W'(w_req_accept) - CNT_W'(w_addr_pop);

  assign w_type      = classify_opcode(mem_resp_data[6:0]);
  assign w_q_entry   = {mem_resp_data, TYPE_WIDTH'(w_type), w_resp_addr};
  assign w_resp_push = w_addr_pop && (r_state == ST_FETCH) && !redirect_valid && !w_q_full;

  fetch_queue #(
    .WIDTH (ADDR_WIDTH),
    .DEPTH (QUEUE_DEPTH)
  ) u_addr_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_req_accept),
    .i_push_data (r_pc),
    .i_pop       (w_addr_pop),
    .i_flush     (1'b0),
    .o_head      (w_resp_addr),
    .o_full      (w_addr_full),
    .o_empty     (w_addr_empty),
    .o_count     (w_outstanding)
  );

  fetch_queue #(
    .WIDTH (ENTRY_W),
    .DEPTH (QUEUE_DEPTH)
  ) u_inst_queue (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_resp_push),
    .i_push_data (w_q_entry),
    .i_pop       (out_valid && out_ready),
    .i_flush     (redirect_valid),
    .o_head      (w_q_head),
    .o_full      (w_q_full),
    .o_empty     (w_q_empty),
    .o_count     (w_occupancy)
  );

  // Head fields are masked while empty because queue storage is not cleared by reset.
  assign out_valid            = !w_q_empty;
  assign out_instruction      = w_q_empty ? '0 : w_q_head[ENTRY_W-1 -: INSTRUCTION_LENGTH];
  assign out_instruction_type = w_q_empty ? '0 : w_q_head[ADDR_WIDTH +: TYPE_WIDTH];
  assign out_pc               = w_q_empty ? '0 : w_q_head[ADDR_WIDTH-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_FETCH;
      r_pc    <= RESET_PC;
    end else begin
      if (redirect_valid)    r_pc <= redirect_pc & ~ADDR_WIDTH'(3);
      else if (w_req_accept) r_pc <= r_pc + ADDR_WIDTH'(4);

      if (redirect_valid)
        r_state <= (w_outstanding_next != '0) ? ST_FLUSH : ST_FETCH;
      else if (r_state == ST_FLUSH && w_outstanding_next == '0)
        r_state <= ST_FETCH;
    end
  end

endmodule
